// File: rtl/pgm_pkg.sv
// Shared helpers for pipelined_group_min: reduction-tree geometry and derived widths.
package pgm_pkg;

  function automatic int pgm_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int pgm_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int pgm_stages(input int n_items);
    return pgm_max(1, pgm_clog2(n_items));
  endfunction

  function automatic int pgm_beat_w(input int max_beats);
    return pgm_max(1, pgm_clog2(max_beats + 1));
  endfunction

  function automatic int pgm_idx_w(input int max_beats, input int n_items);
    return pgm_max(1, pgm_clog2(max_beats * n_items));
  endfunction

  // Node count at a tree level; an odd count rounds up because the spare node passes through.
  function automatic int pgm_level_nodes(input int n_items, input int level);
    int n;
    n = n_items;
    for (int l = 0; l < level; l++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int pgm_level_offset(input int n_items, input int level);
    int off;
    off = 0;
    for (int l = 0; l < level; l++) off += pgm_level_nodes(n_items, l);
    return off;
  endfunction

endpackage

// File: rtl/min_compare_node.sv
// Registered two-input minimum cell; value sits in the top VAL_W bits, ties keep input a.
// One cycle latency, holds its output while en_i is low.
module min_compare_node
  import pgm_pkg::*;
#(
  parameter int VAL_W = 4,
  parameter int DAT_W = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en_i,
  input  logic [DAT_W-1:0] a_i,
  input  logic [DAT_W-1:0] b_i,
  output logic [DAT_W-1:0] y_o
);

  logic [DAT_W-1:0] y_q;
  logic [DAT_W-1:0] y_d;

  always_comb begin
    y_d = a_i;
    if (b_i[DAT_W-1 -: VAL_W] < a_i[DAT_W-1 -: VAL_W]) y_d = b_i;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) y_q <= '0;
    else if (en_i) y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/pipelined_group_min.sv
// Per-beat min tree (STAGES regs) then a group accumulator; result STAGES+1 cycles after last beat.
// Whole pipeline stalls while a result waits on out_ready; PGM_ARGMIN_EN adds out_index.
module pipelined_group_min
  import pgm_pkg::*;
#(
  parameter  int NUM_ITEMS  = 7,
  parameter  int ITEM_WIDTH = 4,
  parameter  int MAX_BEATS  = 16,
  localparam int BEAT_W     = pgm_beat_w(MAX_BEATS)
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_ITEMS*ITEM_WIDTH-1:0] in_items,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ITEM_WIDTH-1:0]           out_min,
  output logic [BEAT_W-1:0]               out_beats,
  output logic                            out_overflow
`ifdef PGM_ARGMIN_EN
  ,
  output logic [pgm_idx_w(MAX_BEATS, NUM_ITEMS)-1:0] out_index
`endif
);

  localparam int STAGES = pgm_stages(NUM_ITEMS);
  localparam int TOTAL  = pgm_level_offset(NUM_ITEMS, STAGES + 1);

`ifdef PGM_ARGMIN_EN
  localparam int IDX_W = pgm_idx_w(MAX_BEATS, NUM_ITEMS);
  typedef struct packed {
    logic [ITEM_WIDTH-1:0] min;
    logic [IDX_W-1:0]      idx;
  } pgm_node_t;
`else
  typedef struct packed {
    logic [ITEM_WIDTH-1:0] min;
  } pgm_node_t;
`endif

  localparam int DAT_W = $bits(pgm_node_t);

  logic                    advance;
  pgm_node_t [TOTAL-1:0]   node;
  logic [STAGES-1:0]       vld_q, vld_d;
  logic [STAGES-1:0]       lst_q, lst_d;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Level 0 is the raw input beat; every later level is registered.
  for (genvar m = 0; m < NUM_ITEMS; m++) begin : g_leaf
    assign node[m].min = in_items[m*ITEM_WIDTH +: ITEM_WIDTH];
`ifdef PGM_ARGMIN_EN
    assign node[m].idx = IDX_W'(m);
`endif
  end

  for (genvar l = 0; l < STAGES; l++) begin : g_lvl
    localparam int NI = pgm_level_nodes(NUM_ITEMS, l);
    localparam int NO = pgm_level_nodes(NUM_ITEMS, l + 1);
    localparam int OI = pgm_level_offset(NUM_ITEMS, l);
    localparam int OO = pgm_level_offset(NUM_ITEMS, l + 1);
    for (genvar k = 0; k < NO; k++) begin : g_node
      localparam int KB = (2*k + 1 < NI) ? 2*k + 1 : 2*k;
      min_compare_node #(
        .VAL_W(ITEM_WIDTH),
        .DAT_W(DAT_W)
      ) u_node (
        .clk  (clk),
        .rstb (rstb),
        .en_i (advance),
        .a_i  (node[OI + 2*k]),
        .b_i  (node[OI + KB]),
        .y_o  (node[OO + k])
      );
    end
  end

  always_comb begin
    vld_d = vld_q;
    lst_d = lst_q;
    if (advance) begin
      vld_d[0] = in_valid;
      lst_d[0] = in_last;
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        lst_d[s] = lst_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= vld_d;
      lst_q <= lst_d;
    end
  end

  pgm_node_t             beat_q;
  logic [ITEM_WIDTH-1:0] acc_min_q, acc_min_d;
  logic                  acc_active_q, acc_active_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0]     cnt_inc;
  logic                  take_beat;
  logic [ITEM_WIDTH-1:0] cand_min;
  logic                  out_valid_q, out_valid_d;
  logic [ITEM_WIDTH-1:0] out_min_q, out_min_d;
  logic [BEAT_W-1:0]     out_beats_q, out_beats_d;
  logic                  out_ovf_q, out_ovf_d;

  assign beat_q    = node[TOTAL-1];
  // Strict less-than: on a tie the earlier beat, and so the lower global index, is kept.
  assign take_beat = !acc_active_q || (beat_q.min < acc_min_q);
  assign cand_min  = take_beat ? beat_q.min : acc_min_q;
  assign cnt_inc   = (beat_cnt_q >= BEAT_W'(MAX_BEATS)) ? beat_cnt_q : beat_cnt_q + BEAT_W'(1);

`ifdef PGM_ARGMIN_EN
  logic [IDX_W-1:0] beat_gidx;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  // beat_cnt is the ordinal of the current beat; past saturation the index is don't-care.
  assign beat_gidx = IDX_W'(beat_cnt_q) * IDX_W'(NUM_ITEMS) + beat_q.idx;
  assign cand_idx  = take_beat ? beat_gidx : acc_idx_q;
`endif

  always_comb begin
    acc_min_d    = acc_min_q;
    acc_active_d = acc_active_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q;
    out_min_d    = out_min_q;
    out_beats_d  = out_beats_q;
    out_ovf_d    = out_ovf_q;
`ifdef PGM_ARGMIN_EN
    acc_idx_d    = acc_idx_q;
    out_idx_d    = out_idx_q;
`endif
    if (advance) begin
      // Advancing with out_valid set implies the held result is being taken this cycle.
      out_valid_d = 1'b0;
      if (vld_q[STAGES-1]) begin
        if (lst_q[STAGES-1]) begin
          out_valid_d  = 1'b1;
          out_min_d    = cand_min;
          out_beats_d  = cnt_inc;
          out_ovf_d    = (beat_cnt_q >= BEAT_W'(MAX_BEATS));
          acc_active_d = 1'b0;
          beat_cnt_d   = '0;
`ifdef PGM_ARGMIN_EN
          out_idx_d    = cand_idx;
`endif
        end else begin
          acc_min_d    = cand_min;
          acc_active_d = 1'b1;
          beat_cnt_d   = cnt_inc;
`ifdef PGM_ARGMIN_EN
          acc_idx_d    = cand_idx;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc_min_q    <= '0;
      acc_active_q <= 1'b0;
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_min_q    <= '0;
      out_beats_q  <= '0;
      out_ovf_q    <= 1'b0;
`ifdef PGM_ARGMIN_EN
      acc_idx_q    <= '0;
      out_idx_q    <= '0;
`endif
    end else begin
      acc_min_q    <= acc_min_d;
      acc_active_q <= acc_active_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_min_q    <= out_min_d;
      out_beats_q  <= out_beats_d;
      out_ovf_q    <= out_ovf_d;
`ifdef PGM_ARGMIN_EN
      acc_idx_q    <= acc_idx_d;
      out_idx_q    <= out_idx_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_min      = out_min_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_ovf_q;
`ifdef PGM_ARGMIN_EN
  assign out_index    = out_idx_q;
`endif

endmodule

// File: tb/tb_pipelined_group_min.sv
// Bench for pipelined_group_min: scoreboarded main instance plus small overflow / width variants.
module tb_pipelined_group_min;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstb;

  // Main instance: 7 items, 16 beats max
  logic        d_iv, d_ir, d_il, d_ov, d_or, d_oovf;
  logic [27:0] d_items;
  logic [3:0]  d_omin;
  logic [4:0]  d_obeats;
  // Overflow instance: 7 items, 4 beats max
  logic        o_iv, o_ir, o_il, o_ov, o_or, o_oovf;
  logic [27:0] o_items;
  logic [3:0]  o_omin;
  logic [2:0]  o_obeats;
  // Width variants: 1 item and 8 items sharing valid/last
  logic        s_iv, s_il, s_or;
  logic        n1_ir, n1_ov, n1_oovf, n8_ir, n8_ov, n8_oovf;
  logic [3:0]  n1_items, n1_omin, n8_omin;
  logic [31:0] n8_items;
  logic [4:0]  n1_obeats, n8_obeats;
`ifdef PGM_ARGMIN_EN
  logic [6:0]  d_oidx, n8_oidx;
  logic [4:0]  o_oidx;
  logic [3:0]  n1_oidx;
`endif

  pipelined_group_min #(.NUM_ITEMS(7), .ITEM_WIDTH(4), .MAX_BEATS(16)) u_dut (
    .clk(clk), .rstb(rstb), .in_valid(d_iv), .in_ready(d_ir), .in_items(d_items), .in_last(d_il),
    .out_valid(d_ov), .out_ready(d_or), .out_min(d_omin), .out_beats(d_obeats), .out_overflow(d_oovf)
`ifdef PGM_ARGMIN_EN
    , .out_index(d_oidx)
`endif
  );

  pipelined_group_min #(.NUM_ITEMS(7), .ITEM_WIDTH(4), .MAX_BEATS(4)) u_ovf (
    .clk(clk), .rstb(rstb), .in_valid(o_iv), .in_ready(o_ir), .in_items(o_items), .in_last(o_il),
    .out_valid(o_ov), .out_ready(o_or), .out_min(o_omin), .out_beats(o_obeats), .out_overflow(o_oovf)
`ifdef PGM_ARGMIN_EN
    , .out_index(o_oidx)
`endif
  );

  pipelined_group_min #(.NUM_ITEMS(1), .ITEM_WIDTH(4), .MAX_BEATS(16)) u_n1 (
    .clk(clk), .rstb(rstb), .in_valid(s_iv), .in_ready(n1_ir), .in_items(n1_items), .in_last(s_il),
    .out_valid(n1_ov), .out_ready(s_or), .out_min(n1_omin), .out_beats(n1_obeats), .out_overflow(n1_oovf)
`ifdef PGM_ARGMIN_EN
    , .out_index(n1_oidx)
`endif
  );

  pipelined_group_min #(.NUM_ITEMS(8), .ITEM_WIDTH(4), .MAX_BEATS(16)) u_n8 (
    .clk(clk), .rstb(rstb), .in_valid(s_iv), .in_ready(n8_ir), .in_items(n8_items), .in_last(s_il),
    .out_valid(n8_ov), .out_ready(s_or), .out_min(n8_omin), .out_beats(n8_obeats), .out_overflow(n8_oovf)
`ifdef PGM_ARGMIN_EN
    , .out_index(n8_oidx)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int mn;
    int beats;
    int ovf;
    int idx;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    int          nb;
    logic [27:0] b0;
    logic [27:0] b1;
    logic [27:0] b2;
    int          emin;
    int          ebeats;
    int          eidx;
  } vec_t;
  vec_t vt[6];

  function automatic logic [27:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6);
    return {4'(a6), 4'(a5), 4'(a4), 4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic exp_t model1(input logic [27:0] b);
    exp_t e;
    e.mn = int'(b[3:0]); e.idx = 0; e.beats = 1; e.ovf = 0;
    for (int m = 1; m < 7; m++)
      if (int'(b[m*4 +: 4]) < e.mn) begin
        e.mn  = int'(b[m*4 +: 4]);
        e.idx = m;
      end
    return e;
  endfunction

  // Must be called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [27:0] items, input logic last);
    int   guard;
    logic acc;
    guard = 0;
    d_iv = 1'b1; d_items = items; d_il = last;
    do begin
      #4 acc = d_ir;
      @(negedge clk);
      guard++;
    end while (!acc && guard < 200);
    if (!acc) chk("send_timeout", 0, 1);
    d_iv = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask

  bit tog_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (tog_en) d_or = ~d_or;
  end

  // Monitor: inspects handshake values mid-cycle, before the next rising edge.
  initial forever begin
    @(negedge clk);
    #4;
    if (rstb) begin
      chk("in_ready_vs_stall", int'(d_ir), int'(!(d_ov && !d_or)));
      if (d_ov && d_or) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("out_min", int'(d_omin), mon_e.mn);
          chk("out_beats", int'(d_obeats), mon_e.beats);
          chk("out_overflow", int'(d_oovf), mon_e.ovf);
`ifdef PGM_ARGMIN_EN
          chk("out_index", int'(d_oidx), mon_e.idx);
`endif
        end
      end
    end
  end

  task automatic ovf_run(input int nb, input int low, input int ebeats, input int eovf);
    int got;
    for (int j = 0; j < nb; j++) begin
      o_iv = 1'b1; o_il = (j == nb - 1);
      o_items = (j == nb - 2) ? pk(9, 9, 9, low, 9, 9, 9) : pk(9, 9, 9, 9, 9, 9, 9);
      #4 chk("ovf_in_ready", int'(o_ir), 1);
      @(negedge clk);
    end
    o_iv = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #4;
      if (o_ov) begin
        got = 1;
        break;
      end
    end
    chk("ovf_result_seen", got, 1);
    chk("ovf_min", int'(o_omin), low);
    chk("ovf_beats", int'(o_obeats), ebeats);
    chk("ovf_flag", int'(o_oovf), eovf);
    @(negedge clk);
  endtask

  exp_t e;
  int   lat, lat1, lat8;

  initial begin
    rstb = 1'b0;
    d_iv = 0; d_il = 0; d_items = '0; d_or = 1'b1;
    o_iv = 0; o_il = 0; o_items = '0; o_or = 1'b1;
    s_iv = 0; s_il = 0; s_or = 1'b1; n1_items = '0; n8_items = '0;

    vt[0] = '{1, pk(3, 9, 1, 7, 1, 15, 4), '0, '0, 1, 1, 2};
    vt[1] = '{3, pk(5, 6, 7, 8, 9, 10, 11), pk(9, 9, 2, 9, 9, 9, 9), pk(2, 3, 4, 5, 6, 7, 8), 2, 3, 9};
    vt[2] = '{1, pk(15, 15, 15, 15, 15, 15, 15), '0, '0, 15, 1, 0};
    vt[3] = '{2, pk(4, 4, 4, 4, 4, 4, 0), pk(0, 0, 0, 0, 0, 0, 0), '0, 0, 2, 6};
    vt[4] = '{1, pk(15, 14, 13, 12, 11, 10, 9), '0, '0, 9, 1, 6};
    vt[5] = '{2, pk(8, 8, 8, 8, 8, 8, 8), pk(8, 8, 8, 8, 8, 8, 7), '0, 7, 2, 13};

    #3;
    chk("rst_out_valid", int'(d_ov), 0);
    chk("rst_out_min", int'(d_omin), 0);
    chk("rst_out_beats", int'(d_obeats), 0);
    chk("rst_out_overflow", int'(d_oovf), 0);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(d_ir), 1);

    // Latency of a single-beat group through the 7-item tree
    e = '{vt[0].emin, 1, 0, vt[0].eidx};
    sb.push_back(e);
    send(vt[0].b0, 1'b1);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 lat++;
      if (d_ov) break;
    end
    chk("latency_7items", lat, 4);
    @(negedge clk);
    wait_drain();

    // Table vectors back to back
    for (int i = 0; i < 6; i++) begin
      e = '{vt[i].emin, vt[i].ebeats, 0, vt[i].eidx};
      sb.push_back(e);
      for (int j = 0; j < vt[i].nb; j++)
        send((j == 0) ? vt[i].b0 : (j == 1) ? vt[i].b1 : vt[i].b2, j == vt[i].nb - 1);
    end
    wait_drain();

    // Stream of single-beat groups under a toggling out_ready
    tog_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [27:0] b;
      b = pk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      sb.push_back(model1(b));
      send(b, 1'b1);
    end
    wait_drain();
    tog_en = 1'b0;
    @(negedge clk);
    d_or = 1'b1;
    @(negedge clk);

    // Reset in the middle of a group while a finished result is being held
    send(pk(6, 6, 6, 6, 6, 6, 5), 1'b1);
    send(pk(1, 1, 1, 1, 1, 1, 1), 1'b0);
    send(pk(1, 1, 1, 1, 1, 1, 1), 1'b0);
    d_or = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #4;
    chk("hold_out_valid", int'(d_ov), 1);
    chk("hold_out_min", int'(d_omin), 5);
    chk("hold_in_ready", int'(d_ir), 0);
    @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("midrst_out_valid", int'(d_ov), 0);
    chk("midrst_out_min", int'(d_omin), 0);
    chk("midrst_out_beats", int'(d_obeats), 0);
    chk("midrst_in_ready", int'(d_ir), 1);
    @(negedge clk);
    rstb = 1'b1;
    d_or = 1'b1;
    @(negedge clk);
    e = '{8, 1, 0, 0};
    sb.push_back(e);
    send(pk(8, 8, 8, 8, 8, 8, 8), 1'b1);
    wait_drain();

    // Beat-count saturation and an exact-limit group
    ovf_run(6, 0, 4, 1);
    ovf_run(4, 1, 4, 0);

    // Degenerate and power-of-two tree widths
    s_iv = 1'b1; s_il = 1'b1; n1_items = 4'hF; n8_items = '1;
    #4;
    chk("n1_in_ready", int'(n1_ir), 1);
    chk("n8_in_ready", int'(n8_ir), 1);
    @(negedge clk);
    s_iv = 1'b0;
    lat1 = 0; lat8 = 0;
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (n1_ov && lat1 == 0) lat1 = c;
      if (n8_ov && lat8 == 0) lat8 = c;
    end
    chk("latency_1item", lat1, 2);
    chk("latency_8items", lat8, 4);
    chk("n1_min", int'(n1_omin), 15);
    chk("n8_min", int'(n8_omin), 15);
    chk("n1_beats", int'(n1_obeats), 1);
    chk("n8_beats", int'(n8_obeats), 1);
`ifdef PGM_ARGMIN_EN
    chk("n1_index", int'(n1_oidx), 0);
    chk("n8_index", int'(n8_oidx), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
